// File: rtl/adc_sampler_pkg.sv
// Shared definitions for the panel-voltage ADC sampler: data width, FSM states
// and the unsigned distance helper used by the glitch filter.
package adc_sampler_pkg;

  localparam int unsigned ADC_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_EOC = 2'd1,
    ST_PUBLISH  = 2'd2
  } state_e;

  // |a - b| computed in ADC_W+1 bits so the sign of the difference is kept
  function automatic logic [ADC_W:0] abs_diff(input logic [ADC_W-1:0] a,
                                              input logic [ADC_W-1:0] b);
    logic [ADC_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[ADC_W] ? (~d + (ADC_W+1)'(1)) : d;
  endfunction

endpackage

// File: rtl/adc_sampler_soc_timer.sv
// Free-running SOC period counter, 0..PERIOD-1, with synchronous clear.
// tick_o is registered and is high exactly while the count sits at PERIOD-1.
module adc_sampler_soc_timer
  import adc_sampler_pkg::*;
#(
  parameter int unsigned PERIOD = 100
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next count: clear wins, otherwise wrap at the terminal count
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    tick_d = !clr_i && (cnt_d == LAST);
  end

  // Count and tick registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/adc_sampler.sv
// Panel-voltage sampler: periodic XADC start-of-conversion, EOC timeout,
// averaging of 2^AVG_LOG2 samples with a one-cycle publish strobe.
// Optional feature macro: GLITCH_FILTER_EN (rejects samples far from V_OUT).
module adc_sampler
  import adc_sampler_pkg::*;
#(
  parameter int unsigned SOC_PERIOD  = 100,
  parameter int unsigned AVG_LOG2    = 3,
  parameter int unsigned EOC_TIMEOUT = 64,
  parameter int unsigned GLITCH_THR  = 200
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ENABLE,
  input  logic             ADC_EOC,
  input  logic [ADC_W-1:0] ADC_DATA,
  output logic             ADC_SOC,
  output logic [ADC_W-1:0] V_OUT,
  output logic             V_VALID,
  output logic             TIMEOUT_ERR,
  output logic             SAMPLE_REJ
);

  localparam int unsigned ACC_W = ADC_W + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam int unsigned TMO_W = $clog2(EOC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(EOC_TIMEOUT - 1);
  localparam logic [ADC_W:0]   THR      = (ADC_W+1)'(GLITCH_THR);

`ifdef GLITCH_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [ADC_W-1:0] v_out_q, v_out_d;
  logic             have_ref_q, have_ref_d;
  logic             terr_q, terr_d;
  logic             soc_q, soc_d;
  logic             valid_q, valid_d;
  logic             rej_q, rej_d;

  logic             tick;
  logic [ACC_W-1:0] acc_sum_c;
  logic [ADC_W-1:0] avg_c;
  logic             reject_c;

  adc_sampler_soc_timer #(
    .PERIOD(SOC_PERIOD)
  ) u_soc_timer (
    .clk_i (CLK),
    .rst_ni(RST_N),
    .clr_i (!ENABLE),
    .tick_o(tick)
  );

  // Running sum including the sample on the bus, its average, and the glitch test
  assign acc_sum_c = acc_q + ACC_W'(ADC_DATA);
  assign avg_c     = ADC_W'(acc_sum_c >> AVG_LOG2);
  assign reject_c  = FILTER_ON && have_ref_q && (abs_diff(ADC_DATA, v_out_q) > THR);

  // Next-state and output decode; ENABLE low flushes from any state
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    v_out_d    = v_out_q;
    have_ref_d = have_ref_q;
    terr_d     = terr_q;
    soc_d      = 1'b0;
    valid_d    = 1'b0;
    rej_d      = 1'b0;
    if (!ENABLE) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      tmo_d   = '0;
      terr_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            soc_d   = 1'b1;
            tmo_d   = TMO_LOAD;
            state_d = ST_WAIT_EOC;
          end
        end
        ST_WAIT_EOC: begin
          if (ADC_EOC) begin
            if (reject_c) begin
              rej_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              acc_d = acc_sum_c;
              cnt_d = cnt_q + CNT_W'(1);
              if (cnt_q == CNT_LAST) begin
                v_out_d = avg_c;
                valid_d = 1'b1;
                state_d = ST_PUBLISH;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end else if (tmo_q == '0) begin
            terr_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            tmo_d = tmo_q - TMO_W'(1);
          end
        end
        ST_PUBLISH: begin
          acc_d      = '0;
          cnt_d      = '0;
          have_ref_d = 1'b1;
          state_d    = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      v_out_q    <= '0;
      have_ref_q <= 1'b0;
      terr_q     <= 1'b0;
      soc_q      <= 1'b0;
      valid_q    <= 1'b0;
      rej_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      v_out_q    <= v_out_d;
      have_ref_q <= have_ref_d;
      terr_q     <= terr_d;
      soc_q      <= soc_d;
      valid_q    <= valid_d;
      rej_q      <= rej_d;
    end
  end

  assign ADC_SOC     = soc_q;
  assign V_OUT       = v_out_q;
  assign V_VALID     = valid_q;
  assign TIMEOUT_ERR = terr_q;
  assign SAMPLE_REJ  = rej_q;

endmodule

// File: tb/tb_adc_sampler.sv
// Bench for adc_sampler: per-scenario tasks against a queue-based average model.
module tb_adc_sampler;

  localparam int unsigned SOC_PERIOD  = 10;
  localparam int unsigned AVG_LOG2    = 2;
  localparam int unsigned EOC_TIMEOUT = 5;
  localparam int unsigned GLITCH_THR  = 100;
  localparam int          NAVG        = 4;

`ifdef GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic        CLK      = 1'b0;
  logic        RST_N    = 1'b0;
  logic        ENABLE   = 1'b0;
  logic        ADC_EOC  = 1'b0;
  logic [11:0] ADC_DATA = 12'd0;
  logic        ADC_SOC;
  logic [11:0] V_OUT;
  logic        V_VALID;
  logic        TIMEOUT_ERR;
  logic        SAMPLE_REJ;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  int last_soc = 0;
  bit stray = 1'b0;

  // Reference model state
  int pend[$];
  int exp_vout = 0;
  bit exp_ref  = 1'b0;
  bit exp_terr = 1'b0;

  adc_sampler #(
    .SOC_PERIOD (SOC_PERIOD),
    .AVG_LOG2   (AVG_LOG2),
    .EOC_TIMEOUT(EOC_TIMEOUT),
    .GLITCH_THR (GLITCH_THR)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .ENABLE     (ENABLE),
    .ADC_EOC    (ADC_EOC),
    .ADC_DATA   (ADC_DATA),
    .ADC_SOC    (ADC_SOC),
    .V_OUT      (V_OUT),
    .V_VALID    (V_VALID),
    .TIMEOUT_ERR(TIMEOUT_ERR),
    .SAMPLE_REJ (SAMPLE_REJ)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
    cyc_n++;
  endtask

  function automatic void model_reset();
    pend.delete();
    exp_vout = 0;
    exp_ref  = 1'b0;
    exp_terr = 1'b0;
  endfunction

  // One EOC with data: filter, collect, publish the integer mean of NAVG samples
  function automatic void model_eoc(input int data, output bit pub, output bit rej);
    int diff;
    int s;
    pub  = 1'b0;
    rej  = 1'b0;
    diff = data - exp_vout;
    if (diff < 0) diff = -diff;
    if (FILT && exp_ref && diff > int'(GLITCH_THR)) begin
      rej = 1'b1;
    end else begin
      pend.push_back(data);
      if (pend.size() == NAVG) begin
        s = 0;
        foreach (pend[i]) s += pend[i];
        exp_vout = s / NAVG;
        exp_ref  = 1'b1;
        pend.delete();
        pub = 1'b1;
      end
    end
  endfunction

  task automatic do_reset();
    RST_N = 1'b0;
    step();
    step();
    RST_N = 1'b1;
    model_reset();
    last_soc = cyc_n;
  endtask

  task automatic wait_soc(output int waited);
    bit seen;
    seen   = 1'b0;
    waited = 0;
    for (int i = 0; i < 3 * int'(SOC_PERIOD) && !seen; i++) begin
      if (stray && $urandom_range(0, 3) == 0) begin
        ADC_EOC  = 1'b1;
        ADC_DATA = 12'($urandom);
      end else begin
        ADC_EOC = 1'b0;
      end
      step();
      waited++;
      if (ADC_SOC === 1'b1) seen = 1'b1;
    end
    ADC_EOC = 1'b0;
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL soc_wait: no ADC_SOC within %0d cycles", 3 * SOC_PERIOD);
    end
  endtask

  // One conversion: EOC d cycles after SOC, or none when d >= EOC_TIMEOUT
  task automatic convert(input string tag, input int data, input int d, output int gap);
    int waited;
    bit pub;
    bit rej;
    wait_soc(waited);
    gap      = cyc_n - last_soc;
    last_soc = cyc_n;
    if (d < int'(EOC_TIMEOUT)) begin
      repeat (d) step();
      ADC_EOC  = 1'b1;
      ADC_DATA = 12'(data);
      step();
      ADC_EOC  = 1'b0;
      ADC_DATA = 12'($urandom);
      model_eoc(data, pub, rej);
      total++;
      if (V_VALID !== pub) begin
        bad++;
        $display("FAIL %s v_valid: got %b expected %b", tag, V_VALID, pub);
      end
      total++;
      if (SAMPLE_REJ !== rej) begin
        bad++;
        $display("FAIL %s sample_rej: got %b expected %b", tag, SAMPLE_REJ, rej);
      end
      total++;
      if (V_OUT !== 12'(exp_vout)) begin
        bad++;
        $display("FAIL %s v_out: got %0d expected %0d", tag, V_OUT, exp_vout);
      end
      total++;
      if (TIMEOUT_ERR !== exp_terr) begin
        bad++;
        $display("FAIL %s timeout_err: got %b expected %b", tag, TIMEOUT_ERR, exp_terr);
      end
      if (pub) begin
        step();
        total++;
        if (V_VALID !== 1'b0) begin
          bad++;
          $display("FAIL %s v_valid_width: got %b expected 0", tag, V_VALID);
        end
      end
    end else begin
      repeat (EOC_TIMEOUT - 1) step();
      total++;
      if (TIMEOUT_ERR !== exp_terr) begin
        bad++;
        $display("FAIL %s terr_early: got %b expected %b", tag, TIMEOUT_ERR, exp_terr);
      end
      step();
      exp_terr = 1'b1;
      total++;
      if (TIMEOUT_ERR !== 1'b1) begin
        bad++;
        $display("FAIL %s terr_set: got %b expected 1", tag, TIMEOUT_ERR);
      end
      total++;
      if (V_VALID !== 1'b0) begin
        bad++;
        $display("FAIL %s terr_valid: got %b expected 0", tag, V_VALID);
      end
    end
  endtask

  task automatic test_reset();
    RST_N  = 1'b0;
    ENABLE = 1'b1;
    repeat (3) step();
    total++;
    if ({ADC_SOC, V_VALID, TIMEOUT_ERR, SAMPLE_REJ} !== 4'b0000 || V_OUT !== 12'd0) begin
      bad++;
      $display("FAIL reset_outputs: got soc=%b valid=%b terr=%b rej=%b v_out=%0d expected all 0",
               ADC_SOC, V_VALID, TIMEOUT_ERR, SAMPLE_REJ, V_OUT);
    end
    RST_N = 1'b1;
    model_reset();
    last_soc = cyc_n;
  endtask

  task automatic test_basic();
    int vals[4] = '{100, 200, 300, 400};
    int gap;
    foreach (vals[i]) begin
      convert("basic", vals[i], 2, gap);
      total++;
      if (gap != int'(SOC_PERIOD)) begin
        bad++;
        $display("FAIL basic soc_period: got %0d expected %0d", gap, SOC_PERIOD);
      end
    end
    total++;
    if (V_OUT !== 12'd250) begin
      bad++;
      $display("FAIL basic_avg: got %0d expected 250", V_OUT);
    end
  endtask

  task automatic test_boundary();
    int ones[4] = '{1, 1, 1, 2};
    int gap;
    do_reset();
    repeat (4) convert("all_ones", 4095, 1, gap);
    total++;
    if (V_OUT !== 12'hFFF) begin
      bad++;
      $display("FAIL all_ones_avg: got %h expected fff", V_OUT);
    end
    do_reset();
    foreach (ones[i]) convert("trunc", ones[i], 3, gap);
    total++;
    if (V_OUT !== 12'd1) begin
      bad++;
      $display("FAIL trunc_avg: got %0d expected 1", V_OUT);
    end
  endtask

  task automatic test_timeout();
    int gap;
    do_reset();
    convert("eoc_at_expiry", 600, int'(EOC_TIMEOUT) - 1, gap);
    convert("timeout", 0, int'(EOC_TIMEOUT), gap);
    repeat (3) convert("after_timeout", 600 + int'($urandom_range(0, 60)), int'($urandom_range(0, 4)), gap);
  endtask

  task automatic test_disable();
    int gap;
    int held;
    do_reset();
    convert("pre_timeout", 0, int'(EOC_TIMEOUT), gap);
    convert("pre_disable", 100, 2, gap);
    convert("pre_disable", 3000, 2, gap);
    wait_soc(gap);
    ENABLE   = 1'b0;
    ADC_EOC  = 1'b1;
    ADC_DATA = 12'd2000;
    held     = exp_vout;
    step();
    pend.delete();
    exp_terr = 1'b0;
    total++;
    if (TIMEOUT_ERR !== 1'b0) begin
      bad++;
      $display("FAIL disable_terr: got %b expected 0", TIMEOUT_ERR);
    end
    for (int i = 0; i < 4; i++) begin
      ADC_EOC = $urandom_range(0, 1) != 0;
      step();
      total++;
      if (ADC_SOC !== 1'b0 || V_VALID !== 1'b0 || V_OUT !== 12'(held)) begin
        bad++;
        $display("FAIL disabled_idle: got soc=%b valid=%b v_out=%0d expected 0 0 %0d",
                 ADC_SOC, V_VALID, V_OUT, held);
      end
    end
    ADC_EOC  = 1'b0;
    ENABLE   = 1'b1;
    last_soc = cyc_n;
    for (int i = 0; i < 4; i++) begin
      convert("reenable", 800, int'($urandom_range(0, 4)), gap);
      if (i == 0) begin
        total++;
        if (gap != int'(SOC_PERIOD)) begin
          bad++;
          $display("FAIL reenable_first_soc: got %0d expected %0d", gap, SOC_PERIOD);
        end
      end
    end
    total++;
    if (V_OUT !== 12'd800) begin
      bad++;
      $display("FAIL reenable_avg: got %0d expected 800", V_OUT);
    end
  endtask

  task automatic test_random();
    int gap;
    int data;
    stray = 1'b1;
    for (int i = 0; i < 40; i++) begin
      data = int'($urandom_range(0, 4095));
      if ($urandom_range(0, 2) != 0) begin
        data = exp_vout + int'($urandom_range(0, 240)) - 120;
        if (data < 0) data = 0;
        if (data > 4095) data = 4095;
      end
      convert("random", data, int'($urandom_range(0, 6)), gap);
    end
    stray = 1'b0;
  endtask

`ifdef GLITCH_FILTER_EN
  task automatic test_glitch();
    int seq[5] = '{250, 400, 260, 240, 250};
    int gap;
    do_reset();
    repeat (4) convert("glitch_ref", 250, 2, gap);
    foreach (seq[i]) convert("glitch", seq[i], 2, gap);
    total++;
    if (V_OUT !== 12'd250) begin
      bad++;
      $display("FAIL glitch_avg: got %0d expected 250", V_OUT);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int gap;
    convert("pre_reset", 3000, 2, gap);
    convert("pre_reset", 0, int'(EOC_TIMEOUT), gap);
    wait_soc(gap);
    #1;
    RST_N = 1'b0;
    #1;
    total++;
    if ({ADC_SOC, V_VALID, TIMEOUT_ERR, SAMPLE_REJ} !== 4'b0000 || V_OUT !== 12'd0) begin
      bad++;
      $display("FAIL reset_mid: got soc=%b valid=%b terr=%b rej=%b v_out=%0d expected all 0",
               ADC_SOC, V_VALID, TIMEOUT_ERR, SAMPLE_REJ, V_OUT);
    end
    ADC_EOC  = 1'b1;
    ADC_DATA = 12'd4000;
    step();
    RST_N = 1'b1;
    model_reset();
    last_soc = cyc_n;
    step();
    ADC_EOC = 1'b0;
    total++;
    if (V_VALID !== 1'b0 || V_OUT !== 12'd0) begin
      bad++;
      $display("FAIL late_eoc: got valid=%b v_out=%0d expected 0 0", V_VALID, V_OUT);
    end
    for (int i = 0; i < 4; i++)
      convert("post_reset", int'($urandom_range(0, 4095)), int'($urandom_range(0, 4)), gap);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_timeout();
    test_disable();
    test_random();
`ifdef GLITCH_FILTER_EN
    test_glitch();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
